// File: rtl/fmul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmul_pipe : 3-stage pipelined floating-point multiplier with RNE rounding,  |
// |             flush-to-zero, range flags and valid/ready backpressure.        |
// | Optional macro FMUL_SPECIAL_EN enables NaN/infinity decode of all-ones exp. |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         overflow,
  output logic         underflow
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam logic signed [E_W-1:0] C_BIAS  = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] C_EMAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] C_EZERO = '0;

  logic w_stall;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------- S1: unpack and multiply ----------------
  logic [EXP_W-1:0]        w_es, w_et;
  logic [PROD_W-1:0]       prod1_d;
  logic signed [E_W-1:0]   esum1_d;
  logic                    zero1_d, nan1_d, inf1_d;

  assign w_es    = s[W-2:MAN_W];
  assign w_et    = t[W-2:MAN_W];
  assign prod1_d = {{SIG_W{1'b0}}, 1'b1, s[MAN_W-1:0]} * {{SIG_W{1'b0}}, 1'b1, t[MAN_W-1:0]};
  assign esum1_d = {2'b00, w_es} + {2'b00, w_et} - C_BIAS;
  assign zero1_d = (w_es == '0) | (w_et == '0);

`ifdef FMUL_SPECIAL_EN
  logic w_s_nan, w_t_nan, w_s_inf, w_t_inf;
  assign w_s_nan = (&w_es) & (|s[MAN_W-1:0]);
  assign w_t_nan = (&w_et) & (|t[MAN_W-1:0]);
  assign w_s_inf = (&w_es) & ~(|s[MAN_W-1:0]);
  assign w_t_inf = (&w_et) & ~(|t[MAN_W-1:0]);
  assign nan1_d  = w_s_nan | w_t_nan | (w_s_inf & (w_et == '0)) | (w_t_inf & (w_es == '0));
  assign inf1_d  = (w_s_inf | w_t_inf) & ~nan1_d;
`else
  assign nan1_d  = 1'b0;
  assign inf1_d  = 1'b0;
`endif

  logic                  v1_q, sign1_q, zero1_q, nan1_q, inf1_q;
  logic signed [E_W-1:0] esum1_q;
  logic [PROD_W-1:0]     prod1_q;

  // ---------------- S2: normalise and round ----------------
  logic                  w_carry, w_l, w_g, w_st, w_rnd;
  logic [MAN_W-1:0]      w_man;
  logic [MAN_W:0]        w_man_r;
  logic signed [E_W-1:0] esum2_d;

  assign w_carry = prod1_q[PROD_W-1];
  assign w_man   = w_carry ? prod1_q[PROD_W-2 -: MAN_W] : prod1_q[PROD_W-3 -: MAN_W];
  assign w_l     = w_carry ? prod1_q[SIG_W]             : prod1_q[MAN_W];
  assign w_g     = w_carry ? prod1_q[MAN_W]             : prod1_q[MAN_W-1];
  assign w_st    = w_carry ? (|prod1_q[MAN_W-1:0])      : (|prod1_q[MAN_W-2:0]);
  assign w_rnd   = w_g & (w_st | w_l);
  assign w_man_r = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rnd};
  assign esum2_d = esum1_q + {{(E_W-1){1'b0}}, w_carry};

  logic                  v2_q, sign2_q, zero2_q, nan2_q, inf2_q, rc2_q;
  logic signed [E_W-1:0] esum2_q;
  logic [MAN_W-1:0]      man2_q;

  // ---------------- S3: exponent adjust, range check, pack ----------------
  logic signed [E_W-1:0] w_e3;
  logic [W-1:0]          w_d3;
  logic                  w_ovf3, w_unf3;

  assign w_e3 = esum2_q + {{(E_W-1){1'b0}}, rc2_q};

  // Priority: special results, then zero operands, then range limits
  always_comb begin
    w_d3   = {sign2_q, w_e3[EXP_W-1:0], man2_q};
    w_ovf3 = 1'b0;
    w_unf3 = 1'b0;
    if (nan2_q) begin
      w_d3 = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (inf2_q) begin
      w_d3 = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero2_q) begin
      w_d3 = {sign2_q, {(W-1){1'b0}}};
    end else if (w_e3 >= C_EMAX) begin
      w_d3   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf3 = 1'b1;
    end else if (w_e3 <= C_EZERO) begin
      w_d3   = {sign2_q, {(W-1){1'b0}}};
      w_unf3 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      zero1_q   <= 1'b0;
      nan1_q    <= 1'b0;
      inf1_q    <= 1'b0;
      esum1_q   <= '0;
      prod1_q   <= '0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      zero2_q   <= 1'b0;
      nan2_q    <= 1'b0;
      inf2_q    <= 1'b0;
      rc2_q     <= 1'b0;
      esum2_q   <= '0;
      man2_q    <= '0;
      out_valid <= 1'b0;
      d         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!w_stall) begin
      v1_q <= in_valid;
      if (in_valid) begin
        sign1_q <= s[W-1] ^ t[W-1];
        zero1_q <= zero1_d;
        nan1_q  <= nan1_d;
        inf1_q  <= inf1_d;
        esum1_q <= esum1_d;
        prod1_q <= prod1_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q <= sign1_q;
        zero2_q <= zero1_q;
        nan2_q  <= nan1_q;
        inf2_q  <= inf1_q;
        rc2_q   <= w_man_r[MAN_W];
        esum2_q <= esum2_d;
        man2_q  <= w_man_r[MAN_W-1:0];
      end
      out_valid <= v2_q;
      if (v2_q) begin
        d         <= w_d3;
        overflow  <= w_ovf3;
        underflow <= w_unf3;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// Testbench for fmul_pipe (FP32 build): directed vectors, backpressure, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] s, t, d;
  logic        in_ready, out_valid, overflow, underflow;

  always #5 clk = ~clk;

  fmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .overflow(overflow), .underflow(underflow)
  );

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [33:0] expq[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {overflow, underflow, d}, derived from real-valued significand arithmetic
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic            sg;
    int              ea, eb, e, sh;
    longint unsigned ma, mb, full, q, rem, half;
    sg = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FMUL_SPECIAL_EN
    begin
      logic a_nan, b_nan, a_inf, b_inf;
      a_nan = (ea == 255) && (a[22:0] != 0);
      b_nan = (eb == 255) && (b[22:0] != 0);
      a_inf = (ea == 255) && (a[22:0] == 0);
      b_inf = (eb == 255) && (b[22:0] == 0);
      if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0))
        return {2'b00, 32'h7FC00000};
      if (a_inf || b_inf) return {2'b00, sg, 8'hFF, 23'h0};
    end
`endif
    if (ea == 0 || eb == 0) return {2'b00, sg, 31'h0};
    ma   = {40'h0, 1'b1, a[22:0]};
    mb   = {40'h0, 1'b1, b[22:0]};
    full = ma * mb;
    e    = ea + eb - 127;
    if (full >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = full >> sh;
    rem  = full - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, sg, 31'h0};
    return {2'b00, sg, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    int         sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'd1;
      3:       e = 8'd254;
      4, 5:    e = 8'($urandom_range(100, 154));
      default: e = 8'($urandom_range(0, 255));
    endcase
    return {1'($urandom), e, (($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom))};
  endfunction

  // One cycle: drive at the negedge, check the settled outputs, advance to the next negedge
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [33:0] exp, input logic ordy, output logic acc);
    in_valid  = iv;
    s         = a;
    t         = b;
    out_ready = ordy;
    #1;
    chk("in_ready", {63'h0, in_ready}, {63'h0, !(out_valid && !out_ready)});
    if (prev_stall) begin
      chk("stall_hold_valid", {63'h0, out_valid}, 64'h1);
      chk("stall_hold_d", {30'h0, overflow, underflow, d}, {30'h0, prev_out});
    end
    if (out_valid) begin
      if (expq.size() == 0)
        chk("unexpected_out", {63'h0, out_valid}, 64'h0);
      else if (out_ready)
        chk("result", {30'h0, overflow, underflow, d}, {30'h0, expq.pop_front()});
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {overflow, underflow, d};
    acc        = iv && in_ready;
    if (acc) expq.push_back(exp);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 60 && expq.size() > 0; i++) step(1'b0, 32'h0, 32'h0, 34'h0, 1'b1, acc);
    chk("drain_empty", 64'(expq.size()), 64'h0);
  endtask

  logic [31:0] bp_a[6], bp_b[6];
  logic        acc;
  int          idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; s = '0; t = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_d", {32'h0, d}, 64'h0);
    chk("rst_flags", {62'h0, overflow, underflow}, 64'h0);
    rst = 1'b0;
    #1 chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);

    // Basic product with exact latency: accept edge plus two more edges
    step(1'b1, 32'h3FC00000, 32'h40000000, {2'b00, 32'h40400000}, 1'b1, acc);
    chk("lat_cycle1", {63'h0, out_valid}, 64'h0);
    step(1'b0, 32'h0, 32'h0, 34'h0, 1'b1, acc);
    chk("lat_cycle2", {63'h0, out_valid}, 64'h0);
    step(1'b0, 32'h0, 32'h0, 34'h0, 1'b1, acc);
    chk("lat_cycle3", {63'h0, out_valid}, 64'h1);
    drain();

    // Directed rounding and range cases, back to back
    step(1'b1, 32'h3F800800, 32'h3F800800, {2'b00, 32'h3F801000}, 1'b1, acc);
    step(1'b1, 32'h3F800001, 32'h3F800001, {2'b00, 32'h3F800002}, 1'b1, acc);
    step(1'b1, 32'h7F000000, 32'h7F000000, {2'b10, 32'h7F800000}, 1'b1, acc);
    step(1'b1, 32'h00800000, 32'h00800000, {2'b01, 32'h00000000}, 1'b1, acc);
    step(1'b1, 32'h00000000, 32'hC0000000, {2'b00, 32'h80000000}, 1'b1, acc);
    step(1'b1, 32'h3FFFFFFF, 32'h3FFFFFFF, model(32'h3FFFFFFF, 32'h3FFFFFFF), 1'b1, acc);
`ifdef FMUL_SPECIAL_EN
    step(1'b1, 32'h7F800000, 32'h00000000, {2'b00, 32'h7FC00000}, 1'b1, acc);
    step(1'b1, 32'hFF800000, 32'h40000000, {2'b00, 32'hFF800000}, 1'b1, acc);
    step(1'b1, 32'h7F800001, 32'h3F800000, {2'b00, 32'h7FC00000}, 1'b1, acc);
`else
    step(1'b1, 32'h7F800000, 32'h40000000, {2'b10, 32'h7F800000}, 1'b1, acc);
`endif
    drain();

    // Backpressure: six back-to-back products, consumer stalls cycles 4-7
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      bp_b[i] = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 6 || expq.size() > 0); c++) begin
      step(idx < 6, bp_a[idx % 6], bp_b[idx % 6], model(bp_a[idx % 6], bp_b[idx % 6]),
           !(c >= 4 && c <= 7), acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd6);
    chk("bp_all_delivered", 64'(expq.size()), 64'h0);

    // Randomized traffic with random bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = rnd_op();
      b = rnd_op();
      step($urandom_range(0, 3) != 0, a, b, model(a, b), $urandom_range(0, 9) < 7, acc);
    end
    drain();

    // Reset mid-flight discards everything in the pipe
    step(1'b1, 32'h3FC00000, 32'h40000000, 34'h0, 1'b1, acc);
    step(1'b1, 32'h40400000, 32'h40400000, 34'h0, 1'b1, acc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("midrst_d", {32'h0, d}, 64'h0);
    chk("midrst_flags", {62'h0, overflow, underflow}, 64'h0);
    expq.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 32'h0, 34'h0, 1'b1, acc);
      chk("midrst_no_output", {63'h0, out_valid}, 64'h0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
